passcode_entry_ctrl: RTL
========================

Name: passcode_entry_ctrl

Overview:
Sequences keypad entry into the 4-bit passcode register. The block collects NUM_DIGITS key digits and forwards each accepted digit to the register via a load strobe. It then compares the full entry against the stored code and produces unlock, fail and lockout indications for the medicine-reminder access path. It counts consecutive failed attempts and enforces a timed lockout.

Parameters:
NUM_DIGITS, 4, digits per passcode entry
MAX_TRIES, 3, consecutive mismatches that trigger lockout
TIMEOUT_CYCLES, 500, idle cycles between keys before a partial entry is abandoned
UNLOCK_CYCLES, 50, cycles Unlock stays asserted
LOCK_CYCLES, 1000, cycles Locked stays asserted

Ports:
Clk  in  1  clock, all logic on posedge
Rst  in  1  synchronous reset, active-high
En  in  1  block enable; 0 aborts any entry in progress
KeyValid  in  1  one-cycle strobe, KeyDigit valid
KeyDigit  in  4  key code; 4'h0-4'hE are digits, 4'hF is CLEAR
StoredCode  in  4*NUM_DIGITS  reference code; first digit in MSBs
RegLoad  out  1  load strobe to the passcode register
RegData  out  4  digit presented to the register
DigitCount  out  clog2(NUM_DIGITS+1)  digits accepted in the current entry
Unlock  out  1  code matched
Fail  out  1  one-cycle mismatch pulse
Locked  out  1  lockout active
FailCount  out  clog2(MAX_TRIES+1)  consecutive mismatches

Behaviour:
- Reset: Rst=1 at posedge has priority over all other inputs. State goes to IDLE. All outputs, the entry shift register and all counters are cleared to 0.
- States: IDLE, COLLECT, CHECK, UNLOCKED, FAILED, LOCKOUT.
- Accepted key: KeyValid=1 and En=1 in IDLE or COLLECT, with KeyDigit != 4'hF.
  - The entry is shifted left by 4 bits and KeyDigit is inserted in the LSBs.
  - DigitCount increments.
  - The next cycle has RegLoad=1 and RegData=KeyDigit. RegLoad is a one-cycle pulse; RegData holds its last value until the next accepted key.
- IDLE -> COLLECT on the first accepted key.
- COLLECT -> CHECK on the key that makes DigitCount reach NUM_DIGITS.
- COLLECT timeout:
  - The idle counter restarts on every accepted key.
  - After TIMEOUT_CYCLES cycles with no key: go to IDLE, clear DigitCount and the entry, leave FailCount unchanged.
  - If a key arrives in the same cycle as timeout expiry, the key wins.
- CLEAR key (4'hF) in IDLE or COLLECT: go to IDLE, clear DigitCount and the entry, no RegLoad, FailCount unchanged.
- CHECK (1 cycle): StoredCode is sampled in this cycle.
  - Match: go to UNLOCKED and set FailCount to 0.
  - Mismatch: FailCount increments. If it reaches MAX_TRIES, go to LOCKOUT; otherwise go to FAILED.
  - DigitCount clears on exit from CHECK.
- UNLOCKED: Unlock=1 for exactly UNLOCK_CYCLES cycles, starting the cycle after CHECK, then go to IDLE.
- FAILED: Fail=1 for exactly 1 cycle, then go to IDLE.
- LOCKOUT: Locked=1 for exactly LOCK_CYCLES cycles, then go to IDLE with FailCount set to 0.
- KeyValid is ignored (no shift, no RegLoad) in CHECK, UNLOCKED, FAILED and LOCKOUT.
- En=0:
  - From IDLE, COLLECT, CHECK, UNLOCKED or FAILED: go to IDLE next cycle. DigitCount and entry clear, Unlock/Fail/RegLoad deassert, FailCount is retained.
  - LOCKOUT is not exited by En=0. The lockout timer keeps running; only Rst or timer expiry ends it.
- Rst asserted mid-entry or mid-lockout: full reset as above, next cycle.
- Counter widths:
  - The timeout counter saturates and never wraps.
  - The lock and unlock counters are sized with clog2 of their parameter.
  - FailCount never exceeds MAX_TRIES.

Test Plan:
1. Match: StoredCode=16'h1234, keys 1,2,3,4 with gaps of 3 cycles -> four RegLoad pulses, each one cycle after its key, with RegData 1,2,3,4. Unlock=1 for 50 cycles, then IDLE, FailCount=0.
2. Mismatch and lockout: StoredCode=16'h1234.
   - Enter 5,6,7,8 -> Fail pulse, FailCount=1.
   - Repeat twice -> FailCount=3, Locked=1 for 1000 cycles.
   - Keys during lockout -> no RegLoad.
   - After expiry: Locked=0, FailCount=0.
3. Timeout: keys 1,2, then 500 idle cycles -> DigitCount returns to 0, no Fail. A key arriving on the expiry cycle -> DigitCount=3.
4. CLEAR and abort:
   - Keys 1,2 then 4'hF -> DigitCount=0, no RegLoad for the F key.
   - Keys 1,2,3 then En=0 for 1 cycle -> IDLE, FailCount unchanged.
5. Reset priority: Rst=1 in the same cycle as KeyValid in COLLECT, and again during LOCKOUT -> all outputs 0 on the next cycle, state IDLE.
6. Parameter override NUM_DIGITS=2, MAX_TRIES=1: keys A,B against StoredCode=8'hAC -> direct entry to LOCKOUT, with no FAILED pulse.

Source files
------------

// File: rtl/passcode_entry_ctrl.sv
// -----------------------------------------------------------------------------
// passcode_entry_ctrl
//
// Collects NUM_DIGITS keypad digits into an entry shift register, forwards
// each accepted digit to the external 4-bit passcode register, then compares
// the complete entry against StoredCode. A match raises Unlock for
// UNLOCK_CYCLES cycles. A mismatch either pulses Fail for one cycle or, once
// MAX_TRIES consecutive mismatches have accumulated, raises Locked for
// LOCK_CYCLES cycles. A partial entry is abandoned after TIMEOUT_CYCLES cycles
// without a key.
//
// Ports
//   Clk         clock, all logic on the rising edge
//   Rst         synchronous active-high reset
//   En          block enable; low aborts any entry (not a lockout)
//   KeyValid    one-cycle strobe qualifying KeyDigit
//   KeyDigit    4'h0..4'hE digit, 4'hF CLEAR
//   StoredCode  reference code, first digit in the MSBs
//   RegLoad     one-cycle load strobe to the passcode register
//   RegData     digit presented to the passcode register (held)
//   DigitCount  digits accepted in the current entry
//   Unlock      code matched
//   Fail        one-cycle mismatch pulse
//   Locked      lockout active
//   FailCount   consecutive mismatches
// -----------------------------------------------------------------------------
module passcode_entry_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 500,
  parameter int UNLOCK_CYCLES  = 50,
  parameter int LOCK_CYCLES    = 1000
) (
  input  logic                                Clk,
  input  logic                                Rst,
  input  logic                                En,
  input  logic                                KeyValid,
  input  logic [3:0]                          KeyDigit,
  input  logic [4*NUM_DIGITS-1:0]             StoredCode,
  output logic                                RegLoad,
  output logic [3:0]                          RegData,
  output logic [$clog2(NUM_DIGITS+1)-1:0]     DigitCount,
  output logic                                Unlock,
  output logic                                Fail,
  output logic                                Locked,
  output logic [$clog2(MAX_TRIES+1)-1:0]      FailCount
);

  localparam int DC_W = $clog2(NUM_DIGITS + 1);
  localparam int FC_W = $clog2(MAX_TRIES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int UL_W = (UNLOCK_CYCLES > 1) ? $clog2(UNLOCK_CYCLES) : 1;
  localparam int LK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  localparam logic [DC_W-1:0] DC_LAST = DC_W'(NUM_DIGITS - 1);
  localparam logic [FC_W-1:0] FC_MAX  = FC_W'(MAX_TRIES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [UL_W-1:0] UL_LAST = UL_W'(UNLOCK_CYCLES - 1);
  localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCK_CYCLES - 1);
  localparam logic [3:0]      KEY_CLEAR = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_CHECK,
    S_UNLOCKED,
    S_FAILED,
    S_LOCKOUT
  } state_t;

  state_t                  state;
  logic [4*NUM_DIGITS-1:0] entry;
  logic [TO_W-1:0]         idle_cnt;
  logic [UL_W-1:0]         unlock_cnt;
  logic [LK_W-1:0]         lock_cnt;
  logic [FC_W-1:0]         fail_next;

  // Idle counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [TO_W-1:0] idle_sat_inc(input logic [TO_W-1:0] v);
    return (v == {TO_W{1'b1}}) ? v : v + TO_W'(1);
  endfunction

  // Mismatch count increment that never passes MAX_TRIES.
  function automatic logic [FC_W-1:0] fail_sat_inc(input logic [FC_W-1:0] v);
    return (v >= FC_MAX) ? FC_MAX : v + FC_W'(1);
  endfunction

  assign fail_next = fail_sat_inc(FailCount);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= S_IDLE;
      entry      <= '0;
      idle_cnt   <= '0;
      unlock_cnt <= '0;
      lock_cnt   <= '0;
      DigitCount <= '0;
      FailCount  <= '0;
      RegLoad    <= 1'b0;
      RegData    <= '0;
      Unlock     <= 1'b0;
      Fail       <= 1'b0;
      Locked     <= 1'b0;
    end else begin
      RegLoad <= 1'b0;
      // Dropping En abandons everything except a running lockout, whose
      // timer must not be escapable by toggling the enable.
      if (!En && state != S_LOCKOUT) begin
        state      <= S_IDLE;
        entry      <= '0;
        DigitCount <= '0;
        idle_cnt   <= '0;
        Unlock     <= 1'b0;
        Fail       <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE, S_COLLECT: begin
            if (KeyValid && KeyDigit == KEY_CLEAR) begin
              state      <= S_IDLE;
              entry      <= '0;
              DigitCount <= '0;
              idle_cnt   <= '0;
            end else if (KeyValid) begin
              entry      <= {entry[4*NUM_DIGITS-5:0], KeyDigit};
              DigitCount <= DigitCount + DC_W'(1);
              RegLoad    <= 1'b1;
              RegData    <= KeyDigit;
              idle_cnt   <= '0;
              state      <= (DigitCount == DC_LAST) ? S_CHECK : S_COLLECT;
            end else if (state == S_COLLECT) begin
              // A key on the expiry cycle is handled above, so it wins.
              if (idle_cnt == TO_LAST) begin
                state      <= S_IDLE;
                entry      <= '0;
                DigitCount <= '0;
                idle_cnt   <= '0;
              end else begin
                idle_cnt <= idle_sat_inc(idle_cnt);
              end
            end
          end

          S_CHECK: begin
            DigitCount <= '0;
            entry      <= '0;
            if (entry == StoredCode) begin
              state      <= S_UNLOCKED;
              Unlock     <= 1'b1;
              unlock_cnt <= '0;
              FailCount  <= '0;
            end else begin
              FailCount <= fail_next;
              if (fail_next == FC_MAX) begin
                state    <= S_LOCKOUT;
                Locked   <= 1'b1;
                lock_cnt <= '0;
              end else begin
                state <= S_FAILED;
                Fail  <= 1'b1;
              end
            end
          end

          S_UNLOCKED: begin
            if (unlock_cnt == UL_LAST) begin
              state  <= S_IDLE;
              Unlock <= 1'b0;
            end else begin
              unlock_cnt <= unlock_cnt + UL_W'(1);
            end
          end

          S_FAILED: begin
            state <= S_IDLE;
            Fail  <= 1'b0;
          end

          S_LOCKOUT: begin
            if (lock_cnt == LK_LAST) begin
              state     <= S_IDLE;
              Locked    <= 1'b0;
              FailCount <= '0;
            end else begin
              lock_cnt <= lock_cnt + LK_W'(1);
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
